// File: rtl/fetch_controller_pkg.sv
// Shared encodings for the multi-cycle fetch/execute controller: state and opcode
// constants plus a small status helper.
package fetch_controller_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned OpW    = 3;

    typedef enum logic [StateW-1:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [OpW-1:0] {
        OpAdd   = 3'b000,
        OpAddi  = 3'b001,
        OpLoad  = 3'b010,
        OpStore = 3'b011,
        OpBeq   = 3'b100,
        OpJmp   = 3'b101,
        OpNop   = 3'b110,
        OpHalt  = 3'b111
    } opcode_e;

    function automatic logic state_busy(state_e st);
        return (st != StIdle) && (st != StHalt);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Control/status bundle between the fetch controller and its datapath/memory side.
interface fetch_controller_if
    import fetch_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);
    logic             Start;
    logic [OpW-1:0]   Opcode;
    logic             Zero;
    logic             Mem_Ready;
    logic             Mem_Read;
    logic             Mem_Write;
    logic             IR_Write;
    logic             Reg_Write;
    logic             PC_Write;
    logic             Branch;
    logic             Busy;
    logic             Halted;
    logic [CNT_W-1:0] Instr_Count;

    modport master (
        output Start, Opcode, Zero, Mem_Ready,
        input  Mem_Read, Mem_Write, IR_Write, Reg_Write, PC_Write, Branch, Busy, Halted,
               Instr_Count
    );

    modport slave (
        input  Start, Opcode, Zero, Mem_Ready,
        output Mem_Read, Mem_Write, IR_Write, Reg_Write, PC_Write, Branch, Busy, Halted,
               Instr_Count
    );
endinterface

// File: rtl/fetch_controller.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and write-back
// control strobes, with a retired-instruction counter stepped on every PC update.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    fetch_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    opcode_e          opcode_q, opcode_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic mem_read, mem_write, ir_write, reg_write, pc_write, branch;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            opcode_q <= OpAdd;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    // Strobes depend only on state, latched opcode, Zero and Mem_Ready; Start only steers IDLE.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.Start) state_d = StFetch;
            end
            StFetch: begin
                mem_read = 1'b1;
                if (bus.Mem_Ready) begin
                    ir_write = 1'b1;
                    opcode_d = opcode_e'(bus.Opcode);
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                case (opcode_q)
                    OpHalt: state_d = StHalt;
                    OpNop: begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                case (opcode_q)
                    OpAdd, OpAddi:   state_d = StWb;
                    OpLoad, OpStore: state_d = StMem;
                    OpBeq: begin
                        pc_write = 1'b1;
                        branch   = bus.Zero;
                        state_d  = StFetch;
                    end
                    OpJmp: begin
                        pc_write = 1'b1;
                        branch   = 1'b1;
                        state_d  = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                if (opcode_q == OpLoad) mem_read = 1'b1;
                else                    mem_write = 1'b1;
                if (bus.Mem_Ready) begin
                    if (opcode_q == OpLoad) begin
                        state_d = StWb;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase

        count_d = pc_write ? count_q + CntOne : count_q;
    end

    assign bus.Mem_Read    = mem_read;
    assign bus.Mem_Write   = mem_write;
    assign bus.IR_Write    = ir_write;
    assign bus.Reg_Write   = reg_write;
    assign bus.PC_Write    = pc_write;
    assign bus.Branch      = branch;
    assign bus.Busy        = state_busy(state_q);
    assign bus.Halted      = (state_q == StHalt);
    assign bus.Instr_Count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a per-cycle vector table through every opcode,
// then hand sequences for HALT/Start, counter wrap, and reset during a STORE.
module tb_fetch_controller;

    localparam int unsigned CntW  = 8;
    localparam int          NRows = 38;

    logic Clk;
    logic Reset;

    fetch_controller_if #(.CNT_W(CntW)) bus ();

    fetch_controller #(.CNT_W(CntW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // exp bit order: {Mem_Read, Mem_Write, IR_Write, Reg_Write, PC_Write, Branch, Busy, Halted}
    typedef struct {
        logic       start;
        logic [2:0] op;
        logic       zero;
        logic       rdy;
        logic [7:0] exp;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[NRows];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t v(logic s, logic [2:0] o, logic z, logic r, logic [7:0] e,
                               logic [7:0] c);
        vec_t t;
        t.start = s; t.op = o; t.zero = z; t.rdy = r; t.exp = e; t.cnt = c;
        return t;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.Mem_Read, bus.Mem_Write, bus.IR_Write, bus.Reg_Write,
                bus.PC_Write, bus.Branch, bus.Busy, bus.Halted};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic z, input logic r);
        bus.Start     = s;
        bus.Opcode    = o;
        bus.Zero      = z;
        bus.Mem_Ready = r;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int busy_bad;
        int pw_seen;

        // IDLE..WB ADD, opcode ignored outside fetch, BEQ taken/not, LOAD with waits, JMP,
        // ADDI, STORE with one wait, NOP, HALT, Start ignored in HALT.
        tbl[0]  = v(1, 3'b000, 0, 0, 8'b00000000, 8'd0);
        tbl[1]  = v(0, 3'b000, 0, 1, 8'b10100010, 8'd0);
        tbl[2]  = v(1, 3'b111, 0, 0, 8'b00000010, 8'd0);
        tbl[3]  = v(0, 3'b111, 1, 1, 8'b00000010, 8'd0);
        tbl[4]  = v(0, 3'b010, 0, 1, 8'b00011010, 8'd0);
        tbl[5]  = v(0, 3'b111, 0, 0, 8'b10000010, 8'd1);
        tbl[6]  = v(0, 3'b100, 0, 1, 8'b10100010, 8'd1);
        tbl[7]  = v(0, 3'b000, 1, 0, 8'b00000010, 8'd1);
        tbl[8]  = v(0, 3'b000, 1, 0, 8'b00001110, 8'd1);
        tbl[9]  = v(0, 3'b100, 0, 1, 8'b10100010, 8'd2);
        tbl[10] = v(0, 3'b000, 1, 0, 8'b00000010, 8'd2);
        tbl[11] = v(0, 3'b000, 0, 0, 8'b00001010, 8'd2);
        tbl[12] = v(0, 3'b010, 0, 1, 8'b10100010, 8'd3);
        tbl[13] = v(0, 3'b011, 0, 0, 8'b00000010, 8'd3);
        tbl[14] = v(0, 3'b011, 0, 1, 8'b00000010, 8'd3);
        tbl[15] = v(0, 3'b000, 0, 0, 8'b10000010, 8'd3);
        tbl[16] = v(0, 3'b000, 0, 0, 8'b10000010, 8'd3);
        tbl[17] = v(0, 3'b000, 0, 0, 8'b10000010, 8'd3);
        tbl[18] = v(0, 3'b000, 0, 1, 8'b10000010, 8'd3);
        tbl[19] = v(0, 3'b000, 0, 0, 8'b00011010, 8'd3);
        tbl[20] = v(0, 3'b101, 0, 1, 8'b10100010, 8'd4);
        tbl[21] = v(0, 3'b000, 0, 0, 8'b00000010, 8'd4);
        tbl[22] = v(0, 3'b000, 0, 0, 8'b00001110, 8'd4);
        tbl[23] = v(0, 3'b001, 0, 1, 8'b10100010, 8'd5);
        tbl[24] = v(0, 3'b000, 0, 0, 8'b00000010, 8'd5);
        tbl[25] = v(0, 3'b000, 0, 0, 8'b00000010, 8'd5);
        tbl[26] = v(0, 3'b000, 0, 0, 8'b00011010, 8'd5);
        tbl[27] = v(0, 3'b011, 0, 1, 8'b10100010, 8'd6);
        tbl[28] = v(0, 3'b000, 0, 0, 8'b00000010, 8'd6);
        tbl[29] = v(0, 3'b000, 0, 0, 8'b00000010, 8'd6);
        tbl[30] = v(0, 3'b000, 0, 0, 8'b01000010, 8'd6);
        tbl[31] = v(0, 3'b000, 0, 1, 8'b01001010, 8'd6);
        tbl[32] = v(0, 3'b110, 0, 1, 8'b10100010, 8'd7);
        tbl[33] = v(0, 3'b000, 0, 0, 8'b00001010, 8'd7);
        tbl[34] = v(0, 3'b111, 0, 1, 8'b10100010, 8'd8);
        tbl[35] = v(0, 3'b000, 0, 0, 8'b00000010, 8'd8);
        tbl[36] = v(1, 3'b000, 0, 0, 8'b00000001, 8'd8);
        tbl[37] = v(0, 3'b000, 0, 0, 8'b00000001, 8'd8);

        // Reset held with Start and Mem_Ready high: everything must stay quiet.
        Reset = 1'b0;
        drive(1, 3'b010, 1, 1);
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_cnt", 32'(bus.Instr_Count), 32'd0);
        Reset = 1'b1;
        #1;
        chk("post_reset_outs", 32'(outs()), 32'h0);

        for (int i = 0; i < NRows; i++) begin
            drive(tbl[i].start, tbl[i].op, tbl[i].zero, tbl[i].rdy);
            #1;
            chk($sformatf("row%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
            chk($sformatf("row%0d_cnt", i), 32'(bus.Instr_Count), 32'(tbl[i].cnt));
            step();
        end

        // HALT is sticky against Start toggling; only Reset leaves it.
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 3'b110, i[1], 1);
            #1;
            chk($sformatf("halt_start%0d", i), 32'(outs()), 32'h01);
            step();
        end
        chk("halt_cnt", 32'(bus.Instr_Count), 32'd8);
        Reset = 1'b0;
        #1;
        chk("halt_reset_outs", 32'(outs()), 32'h0);
        chk("halt_reset_cnt", 32'(bus.Instr_Count), 32'd0);
        step();
        Reset = 1'b1;

        // One NOP, then STORE stalled in MEM and reset mid-access.
        drive(1, 3'b000, 0, 0); #1; step();
        drive(0, 3'b110, 0, 1); #1; step();
        drive(0, 3'b000, 0, 0); #1; step();
        drive(0, 3'b011, 0, 1); #1; step();
        drive(0, 3'b000, 0, 0); #1; step();
        drive(0, 3'b000, 0, 0); #1; step();
        #1;
        chk("store_mem_outs", 32'(outs()), 32'b01000010);
        chk("store_mem_cnt", 32'(bus.Instr_Count), 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        chk("store_abort_outs", 32'(outs()), 32'h0);
        chk("store_abort_cnt", 32'(bus.Instr_Count), 32'd0);
        bus.Mem_Ready = 1'b1;
        step();
        chk("store_abort_edge_outs", 32'(outs()), 32'h0);
        chk("store_abort_edge_cnt", 32'(bus.Instr_Count), 32'd0);
        Reset = 1'b1;

        // 256 NOPs: counter wraps back to zero, Busy never drops.
        drive(1, 3'b000, 0, 0); #1; step();
        busy_bad = 0;
        pw_seen  = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) chk("nop_cnt_mid", 32'(bus.Instr_Count), 32'd128);
            drive(0, 3'b110, 0, 1);
            #1;
            if (bus.Busy !== 1'b1) busy_bad++;
            step();
            drive(0, 3'b000, 0, 0);
            #1;
            if (bus.Busy !== 1'b1) busy_bad++;
            if (bus.PC_Write === 1'b1 && bus.Branch === 1'b0) pw_seen++;
            step();
        end
        chk("nop_busy_drops", 32'(busy_bad), 32'd0);
        chk("nop_pc_writes", 32'(pw_seen), 32'd256);
        chk("nop_cnt_wrap", 32'(bus.Instr_Count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: Fetch_Controller

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of retired-instruction counter.
REQ-002 SHALL have port: Clk  input  1  system clock; all state updates on posedge Clk.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: Start  input  1  level; leaves IDLE when 1.
REQ-005 SHALL have port: Opcode  input  3  instruction opcode field, valid while Mem_Ready=1 in FETCH.
REQ-006 SHALL have port: Zero  input  1  ALU zero flag, sampled in EXEC.
REQ-007 SHALL have port: Mem_Ready  input  1  memory access complete this cycle.
REQ-008 SHALL have port: Mem_Read, Mem_Write  output  1 each  memory strobes.
REQ-009 SHALL have port: IR_Write  output  1  load instruction register.
REQ-010 SHALL have port: Reg_Write  output  1  register file write enable.
REQ-011 SHALL have port: PC_Write  output  1  PC update enable.
REQ-012 SHALL have port: Branch  output  1  PC source select; 0 = PC+1, 1 = branch target.
REQ-013 SHALL have port: Busy, Halted  output  1 each  status.
REQ-014 SHALL have port: Instr_Count  output  CNT_W  retired-instruction count.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 SHALL decode opcodes: 000 ADD, 001 ADDI, 010 LOAD, 011 STORE, 100 BEQ, 101 JMP, 110 NOP, 111 HALT.
REQ-017 IDLE: Start=1 -> FETCH; else stay; all strobes 0.
REQ-018 FETCH: Mem_Read=1 every cycle; Mem_Ready=0 -> stay; Mem_Ready=1 -> IR_Write=1 same cycle, latch Opcode into internal register, -> DECODE.
REQ-019 DECODE: HALT -> HALT; NOP -> PC_Write=1, Branch=0, -> FETCH; all others -> EXEC.
REQ-020 EXEC: ADD/ADDI -> WB; LOAD/STORE -> MEM; BEQ -> PC_Write=1, Branch=Zero, -> FETCH; JMP -> PC_Write=1, Branch=1, -> FETCH.
REQ-021 MEM: LOAD drives Mem_Read=1, STORE drives Mem_Write=1, held until Mem_Ready=1; then LOAD -> WB, STORE -> PC_Write=1, Branch=0, -> FETCH.
REQ-022 WB: Reg_Write=1, PC_Write=1, Branch=0, single cycle, -> FETCH.
REQ-023 HALT: Halted=1, all strobes 0; exit only via Reset; Start ignored.
REQ-024 Branch SHALL be 0 whenever PC_Write=0.
REQ-025 PC_Write, IR_Write, Reg_Write SHALL be single-cycle pulses; Mem_Read/Mem_Write never both 1.
REQ-026 Busy SHALL be 1 in FETCH, DECODE, EXEC, MEM, WB; 0 in IDLE and HALT.
REQ-027 Instr_Count SHALL increment by 1 on every cycle with PC_Write=1; wraps 2^CNT_W-1 -> 0; HALT does not count.
REQ-028 Opcode input SHALL be ignored outside the FETCH/Mem_Ready=1 cycle; decisions use the latched opcode.
REQ-029 Zero SHALL be sampled only in EXEC with latched BEQ; Zero changes elsewhere have no effect.
REQ-030 Outputs SHALL be combinational from current state, latched opcode, Zero and Mem_Ready only; no path from Start to any strobe.

Reset
REQ-031 Reset=0 SHALL asynchronously force state IDLE, latched opcode 000, Instr_Count 0.
REQ-032 During and directly after reset all strobes, Busy and Halted SHALL be 0.
REQ-033 Reset asserted mid-instruction (any state, incl. MEM with strobe active) SHALL abort with no further PC_Write or Reg_Write.

Structure
REQ-034 Shared package SHALL hold state encoding constants (3-bit, IDLE=0..HALT=6) and opcode constants.
REQ-035 SHALL be a single module; no sub-modules; one state register plus one output-decode block.

Verification
REQ-036 Reset, Start=1, ADD fetched with Mem_Ready=1 -> IR_Write cycle 1, DECODE, EXEC, WB with Reg_Write=PC_Write=1, Branch=0; Instr_Count=1 after 5 cycles.
REQ-037 BEQ with Zero=1 in EXEC -> PC_Write=1, Branch=1; repeat with Zero=0 -> PC_Write=1, Branch=0; no Reg_Write either case.
REQ-038 LOAD with Mem_Ready held 0 for 3 MEM cycles -> Mem_Read=1 for those 3 cycles plus the ready cycle, then WB with Reg_Write=1.
REQ-039 CNT_W=8, run 256 NOPs -> Instr_Count returns to 0; Busy stays 1 throughout.
REQ-040 HALT opcode -> Halted=1, Busy=0; Start toggled 10 cycles -> no change; Reset=0 -> IDLE, Halted=0.
REQ-041 Reset=0 asserted mid-MEM of STORE -> Mem_Write drops immediately, no PC_Write, Instr_Count=0.
